// File: rtl/inta_sequencer.sv
// Interrupt-acknowledge sequencer for an 8259A-style PIC.
// Counts INTA pulses, picks the vector source (master, cascaded slave, or
// this device as a slave), drives CAS and data bytes, and issues the
// ISR-set and automatic-EOI strobes.
module inta_sequencer #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inta_n,
   input  logic       sp,
   input  logic       single,
   input  logic       mode_8086,
   input  logic       aeoi,
   input  logic [7:0] icw2,
   input  logic [7:0] icw3,
   input  logic [2:0] addr_lo,
   input  logic       int_pending,
   input  logic [2:0] highest_irq,
   input  logic [2:0] cas_in,
   output logic [2:0] cas_out,
   output logic       cas_oe,
   output logic [7:0] data_out,
   output logic       data_oe,
   output logic       freeze,
   output logic       isr_set,
   output logic [2:0] isr_idx,
   output logic       eoi_clr,
   output logic       busy
);

   // The gap after the last pulse is IDLE itself, so no separate G3 state.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      P1   = 3'd1,
      G1   = 3'd2,
      P2   = 3'd3,
      G2   = 3'd4,
      P3   = 3'd5
   } state_e;

   state_e state_q, state_d;

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] valid_q;
   logic                   prev_q;
   logic                   inta_s, fall, rise;

   logic [2:0] irq_q, id_q, addr_q;
   logic [7:0] icw2_q;
   logic       spur_q, slv_q, sel_q, master_q, single_q, mode_q, aeoi_q;
   logic       isr_done_q, isr_set_q, eoi_clr_q;
   logic       load, p2_entry, last_rise, src;

   assign inta_s = sync_q[SYNC_STAGES-1];
   // prev_q only ever holds a real sample, so reset values flushing out of
   // the synchroniser cannot fake a fall while inta_n is already low.
   assign fall   = prev_q & ~inta_s;
   assign rise   = ~prev_q & inta_s;

   // Synchronise inta_n and track when the chain holds real samples.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '1;
         valid_q <= '0;
         prev_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge value of its neighbour.
         sync_q  <= {sync_q[SYNC_STAGES-2:0], inta_n};
         valid_q <= {valid_q[SYNC_STAGES-2:0], 1'b1};
         prev_q  <= valid_q[SYNC_STAGES-1] & inta_s;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state, sequence events and bus drivers.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      state_d   = state_q;
      load      = 1'b0;
      p2_entry  = 1'b0;
      last_rise = 1'b0;
      data_oe   = 1'b0;
      data_out  = 8'h00;
      src       = master_q ? ~slv_q : sel_q;
      case (state_q)
         IDLE: if (fall) begin state_d = P1; load = 1'b1; end
         P1: begin
            if (rise) state_d = G1;
            if (!mode_q && src) begin data_oe = 1'b1; data_out = 8'hCD; end
         end
         G1: if (fall) begin state_d = P2; p2_entry = 1'b1; end
         P2: begin
            if (rise) begin
               state_d   = mode_q ? IDLE : G2;
               last_rise = mode_q;
            end
            if (src) begin
               data_oe  = 1'b1;
               data_out = mode_q ? {icw2_q[7:3], irq_q} : {addr_q, irq_q, 2'b00};
            end
         end
         G2: if (fall) state_d = P3;
         P3: begin
            if (rise) begin state_d = IDLE; last_rise = 1'b1; end
            if (src) begin data_oe = 1'b1; data_out = icw2_q; end
         end
         default: state_d = IDLE;
      endcase
   end

   // Latch sequence context at pulse-1 fall, slave select at pulse-2 fall, strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q      <= 3'd0;
         id_q       <= 3'd0;
         addr_q     <= 3'd0;
         icw2_q     <= 8'h00;
         spur_q     <= 1'b0;
         slv_q      <= 1'b0;
         sel_q      <= 1'b0;
         master_q   <= 1'b0;
         single_q   <= 1'b0;
         mode_q     <= 1'b0;
         aeoi_q     <= 1'b0;
         isr_done_q <= 1'b0;
         isr_set_q  <= 1'b0;
         eoi_clr_q  <= 1'b0;
      end else begin
         isr_set_q <= 1'b0;
         eoi_clr_q <= 1'b0;
         if (load) begin
            irq_q      <= int_pending ? highest_irq : 3'd7;
            spur_q     <= ~int_pending;
            slv_q      <= sp & ~single & int_pending & icw3[highest_irq];
            id_q       <= icw3[2:0];
            icw2_q     <= icw2;
            addr_q     <= addr_lo;
            master_q   <= sp;
            single_q   <= single;
            mode_q     <= mode_8086;
            aeoi_q     <= aeoi;
            sel_q      <= 1'b0;
            isr_set_q  <= sp & int_pending;
            isr_done_q <= sp & int_pending;
         end
         if (p2_entry && !master_q) begin
            sel_q      <= (cas_in == id_q);
            isr_set_q  <= (cas_in == id_q) & ~spur_q;
            isr_done_q <= (cas_in == id_q) & ~spur_q;
         end
         if (last_rise) eoi_clr_q <= aeoi_q & isr_done_q;
      end
   end

   assign busy    = (state_q != IDLE);
   assign freeze  = busy;
   assign cas_oe  = busy & master_q & ~single_q;
   assign cas_out = (cas_oe && slv_q) ? irq_q : 3'd0;
   assign isr_set = isr_set_q;
   assign isr_idx = irq_q;
   assign eoi_clr = eoi_clr_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: drives INTA pulse trains for master,
// cascaded master, slave, 8080 and spurious cases plus a mid-sequence reset.
module tb_inta_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       inta_n, sp, single, mode_8086, aeoi, int_pending;
   logic [7:0] icw2, icw3;
   logic [2:0] addr_lo, highest_irq, cas_in;
   logic [2:0] cas_out, isr_idx;
   logic [7:0] data_out;
   logic       cas_oe, data_oe, freeze, isr_set, eoi_clr, busy;

   int checks = 0;
   int errors = 0;
   int isr_cnt = 0;
   int eoi_cnt = 0;
   logic [2:0] isr_last = 3'd0;
   int isr_base, eoi_base, isr_n, eoi_n;

   typedef struct {
      logic       data_oe;
      logic [7:0] data_out;
      logic       cas_oe;
      logic [2:0] cas_out;
      logic       freeze;
      logic       busy;
      int         eoi;
   } snap_t;
   snap_t snap [0:3];

   inta_sequencer #(.SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .inta_n(inta_n), .sp(sp), .single(single),
      .mode_8086(mode_8086), .aeoi(aeoi), .icw2(icw2), .icw3(icw3),
      .addr_lo(addr_lo), .int_pending(int_pending), .highest_irq(highest_irq),
      .cas_in(cas_in), .cas_out(cas_out), .cas_oe(cas_oe), .data_out(data_out),
      .data_oe(data_oe), .freeze(freeze), .isr_set(isr_set), .isr_idx(isr_idx),
      .eoi_clr(eoi_clr), .busy(busy)
   );

   always #5 clk = ~clk;

   // Count strobes away from the active edge.
   always @(negedge clk) begin
      if (isr_set) begin
         isr_cnt++;
         isr_last = isr_idx;
      end
      if (eoi_clr) eoi_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic snap_t capture();
      snap_t s;
      s.data_oe  = data_oe;
      s.data_out = data_out;
      s.cas_oe   = cas_oe;
      s.cas_out  = cas_out;
      s.freeze   = freeze;
      s.busy     = busy;
      s.eoi      = eoi_cnt - eoi_base;
      return s;
   endfunction

   task automatic setup(input logic m_sp, input logic m_single, input logic m_8086,
                        input logic m_aeoi, input logic [7:0] m_icw2, input logic [7:0] m_icw3,
                        input logic [2:0] m_addr, input logic m_pend, input logic [2:0] m_irq,
                        input logic [2:0] m_cas);
      sp = m_sp; single = m_single; mode_8086 = m_8086; aeoi = m_aeoi;
      icw2 = m_icw2; icw3 = m_icw3; addr_lo = m_addr; int_pending = m_pend;
      highest_irq = m_irq; cas_in = m_cas;
   endtask

   // Runs np INTA pulses; snap[k] is taken late in pulse k, snap[0] after the end.
   task automatic run_seq(input int np, input bit scramble);
      isr_base = isr_cnt;
      eoi_base = eoi_cnt;
      for (int k = 1; k <= np; k++) begin
         inta_n = 1'b0;
         repeat (8) @(negedge clk);
         snap[k] = capture();
         if (k == 1 && scramble) begin
            icw2 = ~icw2; icw3 = ~icw3; addr_lo = ~addr_lo;
            highest_irq = ~highest_irq; int_pending = ~int_pending;
            mode_8086 = ~mode_8086; aeoi = ~aeoi;
         end
         inta_n = 1'b1;
         repeat (8) @(negedge clk);
      end
      snap[0] = capture();
      isr_n = isr_cnt - isr_base;
      eoi_n = eoi_cnt - eoi_base;
   endtask

   initial begin
      inta_n = 1'b1;
      rst_n  = 1'b0;
      setup(1, 1, 1, 0, 8'h00, 8'h00, 3'd0, 0, 3'd0, 3'd0);
      repeat (3) @(negedge clk);
      check("reset_outputs", {cas_out, cas_oe, data_out, data_oe, freeze, isr_set, isr_idx, eoi_clr, busy}, 32'h0);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("idle_busy", busy, 1'b0);

      // Master 8086 single, inputs scrambled after pulse-1 fall.
      setup(1, 1, 1, 0, 8'h40, 8'h00, 3'd0, 1, 3'd3, 3'd0);
      run_seq(2, 1);
      check("m86_p1_oe", snap[1].data_oe, 1'b0);
      check("m86_p1_frz", {snap[1].freeze, snap[1].busy}, 2'b11);
      check("m86_p2_data", {snap[2].data_oe, snap[2].data_out}, {1'b1, 8'h43});
      check("m86_cas_oe", {snap[1].cas_oe, snap[2].cas_oe}, 2'b00);
      check("m86_isr", {isr_n[3:0], isr_last}, {4'd1, 3'd3});
      check("m86_eoi", eoi_n, 0);
      check("m86_end", {snap[0].busy, snap[0].freeze, snap[0].data_oe}, 3'b000);

      // Master cascaded, slave on IR2.
      setup(1, 0, 1, 0, 8'h40, 8'h04, 3'd0, 1, 3'd2, 3'd0);
      run_seq(2, 0);
      check("mc_p1_cas", {snap[1].cas_oe, snap[1].cas_out}, {1'b1, 3'd2});
      check("mc_p2_cas", {snap[2].cas_oe, snap[2].cas_out, snap[2].data_oe}, {1'b1, 3'd2, 1'b0});
      check("mc_end_cas", snap[0].cas_oe, 1'b0);
      check("mc_isr", {isr_n[3:0], isr_last}, {4'd1, 3'd2});

      // Master cascaded, IR5 has no slave: master supplies the vector.
      setup(1, 0, 1, 0, 8'h40, 8'h04, 3'd0, 1, 3'd5, 3'd0);
      run_seq(2, 0);
      check("mc5_cas", {snap[1].cas_oe, snap[1].cas_out, snap[2].cas_oe, snap[2].cas_out}, {1'b1, 3'd0, 1'b1, 3'd0});
      check("mc5_data", {snap[2].data_oe, snap[2].data_out}, {1'b1, 8'h45});

      // Slave ID 2, addressed.
      setup(0, 0, 1, 0, 8'h70, 8'h02, 3'd0, 1, 3'd6, 3'd2);
      run_seq(2, 0);
      check("sl_p1", {snap[1].data_oe, snap[1].cas_oe}, 2'b00);
      check("sl_p2_data", {snap[2].data_oe, snap[2].data_out}, {1'b1, 8'h76});
      check("sl_isr", {isr_n[3:0], isr_last}, {4'd1, 3'd6});

      // Slave ID 2, not addressed.
      setup(0, 0, 1, 0, 8'h70, 8'h02, 3'd0, 1, 3'd6, 3'd3);
      run_seq(2, 0);
      check("sl_nosel_oe", {snap[1].data_oe, snap[2].data_oe}, 2'b00);
      check("sl_nosel_isr", isr_n, 0);

      // 8080 master, three pulses: CALL, low address, high address.
      setup(1, 1, 0, 0, 8'h12, 8'h00, 3'b101, 1, 3'd1, 3'd0);
      run_seq(3, 0);
      check("m80_p1", {snap[1].data_oe, snap[1].data_out}, {1'b1, 8'hCD});
      check("m80_p2", {snap[2].data_oe, snap[2].data_out}, {1'b1, 8'hA4});
      check("m80_p3", {snap[3].data_oe, snap[3].data_out, snap[3].busy}, {1'b1, 8'h12, 1'b1});
      check("m80_end", {snap[0].busy, snap[0].data_oe}, 2'b00);
      check("m80_isr", isr_n, 1);

      // Spurious request with AEOI on.
      setup(1, 1, 1, 1, 8'h08, 8'h00, 3'd0, 0, 3'd2, 3'd0);
      run_seq(2, 0);
      check("spur_data", {snap[2].data_oe, snap[2].data_out}, {1'b1, 8'h0F});
      check("spur_strobes", {isr_n[3:0], eoi_n[3:0]}, 8'h00);

      // AEOI normal: eoi_clr only after the final rise.
      setup(1, 1, 1, 1, 8'h08, 8'h00, 3'd0, 1, 3'd4, 3'd0);
      run_seq(2, 0);
      check("aeoi_data", snap[2].data_out, 8'h0C);
      check("aeoi_before", snap[2].eoi, 0);
      check("aeoi_after", {isr_n[3:0], eoi_n[3:0]}, 8'h11);

      // Reset during P2 of an 8080 cascaded sequence.
      setup(1, 0, 0, 0, 8'h55, 8'h00, 3'b010, 1, 3'd4, 3'd0);
      inta_n = 1'b0; repeat (8) @(negedge clk);
      inta_n = 1'b1; repeat (8) @(negedge clk);
      inta_n = 1'b0; repeat (8) @(negedge clk);
      check("rst_pre", {data_oe, data_out, cas_oe}, {1'b1, 8'h50, 1'b1});
      rst_n = 1'b0;
      #1;
      check("rst_abort", {cas_out, cas_oe, data_out, data_oe, freeze, isr_set, isr_idx, eoi_clr, busy}, 32'h0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("rst_low_ignored", busy, 1'b0);
      inta_n = 1'b1;
      repeat (8) @(negedge clk);

      // Normal sequence after the abort.
      setup(1, 1, 1, 0, 8'h20, 8'h00, 3'd0, 1, 3'd2, 3'd0);
      run_seq(2, 0);
      check("post_rst_data", {snap[2].data_oe, snap[2].data_out}, {1'b1, 8'h22});
      check("post_rst_isr", {isr_n[3:0], isr_last}, {4'd1, 3'd2});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
